// File: rtl/addsub_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial_pkg
// Description : Shared types and constants for the digit-serial adder/
//               subtractor: FSM state encoding, operation codes and a helper
//               that sizes the digit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_serial_pkg;

    // FSM state encoding.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Operation codes carried on the 'sub' input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Digit counter width: max(1, clog2(ndig)).
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage : addsub_serial_pkg
`default_nettype wire

// File: rtl/addsub_serial_digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder / digit_adder
// Description : full_adder  - single-bit full adder.
//               digit_adder - combinational DIGIT-bit ripple adder built from
//                             full_adder cells.
// Ports       : a, b  - addend bits / digits
//               cin   - carry in
//               s     - sum bit / digit
//               cout  - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule : full_adder

module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);
    // w_c[i] is the carry into bit i; w_c[DIGIT] leaves the digit.
    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (w_c[i]),
                .s    (s[i]),
                .cout (w_c[i+1])
            );
        end
    endgenerate

    assign cout = w_c[DIGIT];
endmodule : digit_adder
`default_nettype wire

// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial
// Description : Digit-serial adder/subtractor. Adds or subtracts two WIDTH-bit
//               operands DIGIT bits per clock over WIDTH/DIGIT cycles and
//               reports result plus carry, overflow, zero and negative flags.
// Ports       : clk    - clock, all state on rising edge
//               rst    - synchronous active-high reset
//               start  - request, accepted only when busy=0
//               sub    - 0 = A+B, 1 = A-B (sampled with start)
//               a, b   - operands (sampled with start)
//               busy   - operation in progress
//               done   - one-cycle pulse, result/flags updated
//               result - sum/difference, held until next done
//               cout   - final carry out (subtract: 1 = no borrow)
//               ovf    - two's-complement overflow
//               zero   - result == 0
//               neg    - result MSB
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    // Guarded so an illegal DIGIT reaches the elaboration error below rather
    // than a divide-by-zero.
    localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW   = cnt_width(NDIG);
    localparam int MSB  = WIDTH - 1;

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) ||
            ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_param_err
            $error("addsub_serial: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            r_state_q,  w_state_d;
    logic [WIDTH-1:0]  r_opa_q,    w_opa_d;
    logic [WIDTH-1:0]  r_opb_q,    w_opb_d;
    logic              r_carry_q,  w_carry_d;
    logic [CW-1:0]     r_cnt_q,    w_cnt_d;
    logic [WIDTH-1:0]  r_acc_q,    w_acc_d;
    logic              r_busy_q,   w_busy_d;
    logic              r_done_q,   w_done_d;
    logic [WIDTH-1:0]  r_result_q, w_result_d;
    logic              r_cout_q,   w_cout_d;
    logic              r_ovf_q,    w_ovf_d;
    logic              r_zero_q,   w_zero_d;
    logic              r_neg_q,    w_neg_d;

    // ------------------------------------------------------------------------
    // Current digit slice and its adder
    // ------------------------------------------------------------------------
    int               w_base;
    logic [DIGIT-1:0] w_dig_a;
    logic [DIGIT-1:0] w_dig_b;
    logic [DIGIT-1:0] w_dig_s;
    logic             w_dig_c;
    logic             w_last;

    assign w_base  = int'(r_cnt_q) * DIGIT;
    assign w_dig_a = r_opa_q[w_base +: DIGIT];
    assign w_dig_b = r_opb_q[w_base +: DIGIT];
    assign w_last  = (r_cnt_q == CW'(NDIG - 1));

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a    (w_dig_a),
        .b    (w_dig_b),
        .cin  (r_carry_q),
        .s    (w_dig_s),
        .cout (w_dig_c)
    );

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_opa_d    = r_opa_q;
        w_opb_d    = r_opb_q;
        w_carry_d  = r_carry_q;
        w_cnt_d    = r_cnt_q;
        w_acc_d    = r_acc_q;
        w_busy_d   = r_busy_q;
        w_done_d   = 1'b0;
        w_result_d = r_result_q;
        w_cout_d   = r_cout_q;
        w_ovf_d    = r_ovf_q;
        w_zero_d   = r_zero_q;
        w_neg_d    = r_neg_q;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the
                    // carry with the operation bit.
                    w_state_d = ST_RUN;
                    w_busy_d  = 1'b1;
                    w_opa_d   = a;
                    w_opb_d   = (sub == OP_SUB) ? ~b : b;
                    w_carry_d = (sub == OP_SUB);
                    w_cnt_d   = '0;
                end
            end

            ST_RUN: begin
                w_acc_d[w_base +: DIGIT] = w_dig_s;
                w_carry_d                = w_dig_c;
                if (w_last) begin
                    w_state_d  = ST_IDLE;
                    w_busy_d   = 1'b0;
                    w_done_d   = 1'b1;
                    w_cnt_d    = '0;
                    // Publish the accumulator including the digit just summed.
                    w_result_d = w_acc_d;
                    w_cout_d   = w_dig_c;
                    // Overflow: operands (B already inverted for subtract)
                    // agree in sign but the result sign differs.
                    w_ovf_d    = (r_opa_q[MSB] == r_opb_q[MSB]) &&
                                 (w_dig_s[DIGIT-1] != r_opa_q[MSB]);
                    w_zero_d   = (w_acc_d == '0);
                    w_neg_d    = w_acc_d[MSB];
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_opa_q    <= '0;
            r_opb_q    <= '0;
            r_carry_q  <= 1'b0;
            r_cnt_q    <= '0;
            r_acc_q    <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
            r_result_q <= '0;
            r_cout_q   <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_zero_q   <= 1'b0;
            r_neg_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_opa_q    <= w_opa_d;
            r_opb_q    <= w_opb_d;
            r_carry_q  <= w_carry_d;
            r_cnt_q    <= w_cnt_d;
            r_acc_q    <= w_acc_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
            r_result_q <= w_result_d;
            r_cout_q   <= w_cout_d;
            r_ovf_q    <= w_ovf_d;
            r_zero_q   <= w_zero_d;
            r_neg_q    <= w_neg_d;
        end
    end

    assign busy   = r_busy_q;
    assign done   = r_done_q;
    assign result = r_result_q;
    assign cout   = r_cout_q;
    assign ovf    = r_ovf_q;
    assign zero   = r_zero_q;
    assign neg    = r_neg_q;

endmodule : addsub_serial
`default_nettype wire
